motion_sequencer: RTL and testbench
===================================

Name: motion_sequencer

Overview:
- Timed command scheduler in front of the dual-channel PWM motor driver.
- Accepts two-byte motion frames (action code, duration) from the byte receiver over a valid/ready handshake, and buffers them in a small FIFO.
- Replays the buffered frames onto the driver's 8-bit action input, one frame at a time, each for an exact duration.
- Inserts a short idle dead-time between differing motion commands, and provides an immediate abort.

Parameters:
- TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz).
- FIFO_DEPTH, 4, frame FIFO entries; must be a power of 2, >= 2.
- GAP_TICKS, 20, idle dead-time ticks inserted between two different non-idle commands; 0 disables the gap.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  sequencer accepts rx_data this cycle.
- action  output  8  registered action code to the PWM driver: 0x30 idle, 0x31 forward, 0x32 reverse, 0x33 left, 0x34 right.
- busy  output  1  executor is not in S_IDLE.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of frames buffered.
- err_pulse  output  1  one-cycle pulse when an invalid command byte is rejected.

Behaviour:
- Reset values:
  - action=0x30, busy=0, fifo_count=0, err_pulse=0.
  - rx_ready=1; the parser is in P_CMD, the executor in S_IDLE, the FIFO is empty.
- Handshake: a byte transfers on any edge with rx_valid && rx_ready.
  - rx_ready = (parser==P_CMD) || !fifo_full.
- Parser, state P_CMD:
  - 0x30..0x34: latch as pending cmd, go to P_DUR.
  - 0x53 ('S'): abort; stay in P_CMD.
  - Any other byte: discard, pulse err_pulse next cycle, stay in P_CMD.
- Parser, state P_DUR:
  - Byte = duration d in ticks (0..255).
  - d>0: push {cmd,d} into the FIFO on the same edge; return to P_CMD.
  - d==0: drop the frame (no push, no error); return to P_CMD.
- Abort:
  - The FIFO is flushed on the accepting edge.
  - From the next cycle: executor in S_IDLE, action=0x30, duration and gap counters cleared.
  - Abort overrides any executor transition in the same cycle.
- Executor FSM:
  - S_IDLE: action=0x30. When the FIFO is not empty, go to S_LOAD.
  - S_LOAD: pop the head frame (1 cycle); action holds its previous value.
    - If GAP_TICKS>0, the last executed cmd is non-idle, the new cmd is non-idle and the two differ: go to S_GAP.
    - Otherwise go to S_RUN.
  - S_GAP: action=0x30 for exactly GAP_TICKS*TICK_DIV cycles, then S_RUN.
  - S_RUN: action=cmd for exactly d*TICK_DIV cycles.
    - At expiry, if the FIFO is not empty go to S_LOAD, else go to S_IDLE.
  - "Last executed cmd" resets to 0x30 and is set to 0x30 on entering S_IDLE.
- Timing:
  - The tick prescaler restarts on every entry to S_GAP or S_RUN, so durations are cycle-exact.
  - Durations are counted with a down-counter (8-bit tick count plus clog2(TICK_DIV)-bit prescaler).
- Latency:
  - The duration byte is accepted at edge k with the FIFO empty and the executor idle.
  - S_LOAD is entered at edge k+1 and S_RUN at edge k+2; action = cmd from edge k+2.
- Back-to-back frames: at most one S_LOAD cycle separates frames. Identical consecutive commands show no idle glitch.
- FIFO:
  - Push and pop may occur in the same cycle; fifo_count is then unchanged.
  - When full, a duration byte stalls via rx_ready=0. A command byte is still accepted, so an abort is never blocked.
- busy = (executor != S_IDLE). busy and fifo_count are registered.

Decomposition:
- Package motion_pkg:
  - Action code constants 0x30..0x34 and ABORT_BYTE=0x53.
  - Parser state enum {P_CMD,P_DUR}.
  - Executor state enum {S_IDLE,S_LOAD,S_GAP,S_RUN}.
  - Frame type {cmd[7:0], dur[7:0]}.
- Sub-module motion_fifo: synchronous FIFO, 16 bits wide, depth FIFO_DEPTH, with flush input, full/empty flags and count output.

Test Plan:
All scenarios use TICK_DIV=10, GAP_TICKS=2, FIFO_DEPTH=4.
- Single frame: send 0x31,0x03 -> action=0x31 from 2 cycles after the duration byte, held exactly 30 cycles, then 0x30; busy falls with it.
- Gap insertion: send 0x31,0x02 then 0x32,0x02 -> 0x31 for 20 cycles, 1 LOAD cycle still 0x31, 0x30 for 20 cycles, 0x32 for 20 cycles. Repeating the test with 0x31,0x02 twice -> no 0x30 in between.
- Backpressure: send 5 frames while the first is running -> rx_ready drops on the 5th duration byte until the first pop; fifo_count peaks at 4; all 5 commands execute in order.
- Abort mid-run: send 0x33,0xFF, 0x34,0x05, then 0x53 during the first frame -> action=0x30 the cycle after the 'S' handshake; fifo_count=0; busy=0; the 0x34 frame never appears.
- Invalid and zero: send 0x41 -> err_pulse high 1 cycle, parser stays in P_CMD. Send 0x31,0x00 -> no FIFO push, action stays 0x30.
- Reset mid-run: assert rst during S_RUN -> next cycle action=0x30, fifo_count=0, rx_ready=1.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types and constants for the timed motion command sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package motion_pkg;

    localparam logic [7:0] ACT_IDLE   = 8'h30;
    localparam logic [7:0] ACT_FWD    = 8'h31;
    localparam logic [7:0] ACT_REV    = 8'h32;
    localparam logic [7:0] ACT_LEFT   = 8'h33;
    localparam logic [7:0] ACT_RIGHT  = 8'h34;
    localparam logic [7:0] ABORT_BYTE = 8'h53;

    typedef enum logic {
        P_CMD,
        P_DUR
    } parse_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_RUN
    } exec_state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] dur;
    } frame_t;

    // True for the five codes the PWM driver understands.
    function automatic logic is_motion_cmd(input logic [7:0] b);
        case (b)
            ACT_IDLE, ACT_FWD, ACT_REV, ACT_LEFT, ACT_RIGHT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// Byte-receiver handshake plus driver-facing status of the motion sequencer.
// Latency: none (wiring only).
// Backpressure: rx_ready is owned by the sequencer side.
interface motion_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    action;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          err_pulse;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, action, busy, fifo_count, err_pulse
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, action, busy, fifo_count, err_pulse
    );

endinterface

// File: rtl/motion_fifo.sv
// Synchronous frame FIFO with first-word fall-through read and a flush.
// Latency: pushed word visible on pop_data the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module motion_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/motion_sequencer.sv
// Parses {cmd,dur} byte pairs, buffers them, and replays each cmd on action for dur ticks.
// Latency: action = cmd two cycles after the duration byte when idle; S_LOAD adds one cycle between frames.
// Backpressure: rx_ready drops only for a duration byte while the FIFO is full; command bytes (and abort) always pass.
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_TICKS  = 20
) (
    input  logic              clk,
    input  logic              rst,
    motion_sequencer_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_RELOAD = PW'(TICK_DIV - 1);
    localparam logic [7:0]    GAP_RELOAD = (GAP_TICKS > 0) ? 8'(GAP_TICKS - 1) : 8'd0;

    // Parser
    parse_state_t  parse_q;
    parse_state_t  parse_d;
    logic [7:0]    pend_cmd_q;
    logic          err_q;
    logic          hs;
    logic          push;
    logic          abort;
    logic          bad_byte;
    logic          latch_cmd;

    // FIFO
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [CW-1:0] fifo_cnt;
    frame_t        head;

    // Executor
    exec_state_t   state_q;
    exec_state_t   state_d;
    frame_t        cur_q;
    logic [7:0]    action_q;
    logic [7:0]    action_d;
    logic          busy_q;
    logic          busy_d;
    logic [7:0]    tick_q;
    logic [PW-1:0] pre_q;
    logic          expire;
    logic          need_gap;

    assign bus.rx_ready   = (parse_q == P_CMD) || !fifo_full;
    assign hs             = bus.rx_valid && bus.rx_ready;
    assign bus.action     = action_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_count = fifo_cnt;
    assign bus.err_pulse  = err_q;

    // Byte classification and parser next state.
    always_comb begin
        parse_d   = parse_q;
        push      = 1'b0;
        abort     = 1'b0;
        bad_byte  = 1'b0;
        latch_cmd = 1'b0;
        if (hs) begin
            case (parse_q)
                P_CMD: begin
                    if (is_motion_cmd(bus.rx_data)) begin
                        latch_cmd = 1'b1;
                        parse_d   = P_DUR;
                    end else if (bus.rx_data == ABORT_BYTE) begin
                        abort = 1'b1;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                default: begin
                    // A zero duration silently drops the frame.
                    parse_d = P_CMD;
                    push    = (bus.rx_data != 8'd0);
                end
            endcase
        end
    end

    // Parser state, pending command byte and the registered error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            parse_q    <= P_CMD;
            pend_cmd_q <= ACT_IDLE;
            err_q      <= 1'b0;
        end else begin
            parse_q <= parse_d;
            err_q   <= bad_byte;
            if (latch_cmd) begin
                pend_cmd_q <= bus.rx_data;
            end
        end
    end

    motion_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (push),
        .push_data ({pend_cmd_q, bus.rx_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign pop    = (state_q == S_LOAD);
    assign expire = (pre_q == '0) && (tick_q == 8'd0);
    // cur_q.cmd still holds the previously executed command while in S_LOAD.
    assign need_gap = (GAP_TICKS > 0) && (cur_q.cmd != ACT_IDLE) &&
                      (head.cmd != ACT_IDLE) && (head.cmd != cur_q.cmd);

    // Executor state register plus its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            action_q <= ACT_IDLE;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            action_q <= action_d;
            busy_q   <= busy_d;
        end
    end

    // Executor next state; abort forces idle regardless of the timers.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!fifo_empty) state_d = S_LOAD;
            S_LOAD: state_d = need_gap ? S_GAP : S_RUN;
            S_GAP:  if (expire) state_d = S_RUN;
            S_RUN:  if (expire) state_d = fifo_empty ? S_IDLE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Output decode from the next state so action/busy change on the transition edge.
    always_comb begin
        action_d = action_q;
        busy_d   = (state_d != S_IDLE);
        case (state_d)
            S_IDLE, S_GAP: action_d = ACT_IDLE;
            S_RUN:         action_d = (state_q == S_LOAD) ? head.cmd : cur_q.cmd;
            default:       action_d = action_q;
        endcase
    end

    // Current frame; reverts to idle whenever the executor goes idle so no gap follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= {ACT_IDLE, 8'd0};
        end else if (state_d == S_IDLE) begin
            cur_q <= {ACT_IDLE, 8'd0};
        end else if (state_q == S_LOAD) begin
            cur_q <= head;
        end
    end

    // Tick down-counter with prescaler, restarted on each entry to S_GAP or S_RUN.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            tick_q <= 8'd0;
            pre_q  <= '0;
        end else if ((state_d != state_q) && (state_d == S_RUN)) begin
            tick_q <= ((state_q == S_LOAD) ? head.dur : cur_q.dur) - 8'd1;
            pre_q  <= PRE_RELOAD;
        end else if ((state_d != state_q) && (state_d == S_GAP)) begin
            tick_q <= GAP_RELOAD;
            pre_q  <= PRE_RELOAD;
        end else if (((state_q == S_GAP) || (state_q == S_RUN)) && !expire) begin
            if (pre_q == '0) begin
                pre_q  <= PRE_RELOAD;
                tick_q <= tick_q - 8'd1;
            end else begin
                pre_q <= pre_q - PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer with TICK_DIV=10, GAP_TICKS=2, FIFO_DEPTH=4.
// Action runs seen while busy are compared against an expected-run queue.
// Parser corner cases come from a vector table; timing corners are hand sequences.
module tb_motion_sequencer;
    import motion_pkg::*;

    localparam int T = 10;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    motion_sequencer_if #(.FIFO_DEPTH(4)) bus();

    motion_sequencer #(
        .TICK_DIV   (T),
        .FIFO_DEPTH (4),
        .GAP_TICKS  (G)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] val;
        int         len;
    } seg_t;

    typedef struct {
        logic [7:0] b0;
        bit         two;
        logic [7:0] b1;
        bit         exp_err;
    } vec_t;

    seg_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b0;
    logic [7:0] run_val  = 8'h00;
    int         run_len  = 0;
    int         peak_cnt = 0;
    logic [7:0] bf_cmd [8];
    int         bf_dur [8];
    int         bn;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Run monitor: a run is a maximal stretch of busy cycles with constant action.
    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(bus.fifo_count) > peak_cnt) peak_cnt = int'(bus.fifo_count);
            if (run_len > 0 && (!bus.busy || bus.action != run_val)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL run_unexpected: action 0x%0h for %0d cycles, none expected", run_val, run_len);
                end else begin
                    seg_t e;
                    e = exp_q.pop_front();
                    check("run_value", run_val, e.val);
                    check("run_length", run_len, e.len);
                end
                run_len = 0;
            end
            if (bus.busy) begin
                if (run_len == 0) run_val = bus.action;
                run_len++;
            end
        end
    end

    task automatic add_seg(input logic [7:0] v, input int l, input bit can_merge);
        seg_t s;
        if (can_merge && exp_q.size() > 0 && exp_q[exp_q.size()-1].val == v) begin
            s = exp_q.pop_back();
            s.len += l;
            exp_q.push_back(s);
        end else begin
            s.val = v;
            s.len = l;
            exp_q.push_back(s);
        end
    endtask

    // Expected runs for frames bf_* executed back to back from idle.
    task automatic exp_burst();
        add_seg(ACT_IDLE, 1, 1'b0);
        for (int i = 0; i < bn; i++) begin
            if (i > 0 && bf_cmd[i] != bf_cmd[i-1]) add_seg(ACT_IDLE, G*T, 1'b1);
            add_seg(bf_cmd[i], bf_dur[i]*T, 1'b1);
            if (i < bn-1) add_seg(bf_cmd[i], 1, 1'b1);
        end
    endtask

    // Returns #1 after the accepting edge; acc is that edge's cycle number.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int guard;
        guard = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.rx_ready) begin
            n_checks++;
            $display("FAIL send_timeout: byte 0x%0h not accepted after %0d cycles", b, guard);
            acc = -1;
        end else begin
            @(posedge clk); #1;
            acc = cyc;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, output int acc);
        int a0;
        send_byte(c, a0);
        send_byte(d, acc);
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((bus.busy || bus.fifo_count != 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            n_checks++;
            $display("FAIL %s_timeout: busy=%0b fifo_count=%0d after %0d cycles", name, bus.busy, bus.fifo_count, guard);
        end
        repeat (3) @(negedge clk);
        check({name, "_runs_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[8];
        int   k;
        int   m;
        int   r;
        int   acc_f;

        vt[0] = '{8'h41, 1'b0, 8'h00, 1'b1};
        vt[1] = '{8'h00, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'h35, 1'b0, 8'h00, 1'b1};
        vt[3] = '{8'h2F, 1'b0, 8'h00, 1'b1};
        vt[4] = '{8'h31, 1'b1, 8'h00, 1'b0};
        vt[5] = '{8'h53, 1'b0, 8'h00, 1'b0};
        vt[6] = '{8'h34, 1'b1, 8'h00, 1'b0};
        vt[7] = '{8'hFF, 1'b0, 8'h00, 1'b1};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_action", bus.action, 8'h30);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_fifo_count", bus.fifo_count, 0);
        check("reset_err", bus.err_pulse, 1'b0);
        check("reset_rx_ready", bus.rx_ready, 1'b1);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Parser vectors: invalid bytes, zero durations, idle abort.
        for (int i = 0; i < 8; i++) begin
            send_byte(vt[i].b0, k);
            if (vt[i].two) send_byte(vt[i].b1, k);
            @(negedge clk);
            check($sformatf("err_after_%02h", vt[i].b0), bus.err_pulse, vt[i].exp_err);
            check($sformatf("count_after_%02h", vt[i].b0), bus.fifo_count, 0);
            check($sformatf("action_after_%02h", vt[i].b0), bus.action, 8'h30);
            @(negedge clk);
            check($sformatf("err_width_%02h", vt[i].b0), bus.err_pulse, 1'b0);
            check($sformatf("busy_after_%02h", vt[i].b0), bus.busy, 1'b0);
        end

        // Single frame with latency checks.
        bf_cmd[0] = 8'h31; bf_dur[0] = 3; bn = 1;
        exp_burst();
        send_frame(8'h31, 8'h03, k);
        @(negedge clk);
        check("single_busy_k", bus.busy, 1'b0);
        check("single_count_k", bus.fifo_count, 1);
        @(negedge clk);
        check("single_busy_load", bus.busy, 1'b1);
        check("single_action_load", bus.action, 8'h30);
        @(negedge clk);
        check("single_action_run", bus.action, 8'h31);
        check("single_count_run", bus.fifo_count, 0);
        wait_idle("single");

        // Differing commands get the idle gap.
        bf_cmd[0] = 8'h31; bf_dur[0] = 2;
        bf_cmd[1] = 8'h32; bf_dur[1] = 2; bn = 2;
        exp_burst();
        send_frame(8'h31, 8'h02, k);
        send_frame(8'h32, 8'h02, k);
        wait_idle("gap");

        // Identical commands merge with no idle between them.
        bf_cmd[1] = 8'h31; bn = 2;
        exp_burst();
        send_frame(8'h31, 8'h02, k);
        send_frame(8'h31, 8'h02, k);
        wait_idle("same");

        // Backpressure: six frames, the last duration byte stalls until the first queued pop.
        bf_cmd[0] = 8'h31; bf_dur[0] = 5;
        bf_cmd[1] = 8'h32; bf_dur[1] = 1;
        bf_cmd[2] = 8'h33; bf_dur[2] = 1;
        bf_cmd[3] = 8'h34; bf_dur[3] = 1;
        bf_cmd[4] = 8'h31; bf_dur[4] = 1;
        bf_cmd[5] = 8'h32; bf_dur[5] = 1; bn = 6;
        peak_cnt = 0;
        exp_burst();
        send_frame(bf_cmd[0], 8'(bf_dur[0]), k);
        for (int i = 1; i < 5; i++) send_frame(bf_cmd[i], 8'(bf_dur[i]), m);
        send_byte(bf_cmd[5], m);
        check("bp_rx_ready_full", bus.rx_ready, 1'b0);
        check("bp_count_full", bus.fifo_count, 4);
        send_byte(8'(bf_dur[5]), acc_f);
        check("bp_stall_release_cycle", acc_f, k + 54);
        wait_idle("backpressure");
        check("bp_peak_count", peak_cnt, 4);

        // Abort during a long run; the queued frame must never play.
        add_seg(ACT_IDLE, 1, 1'b0);
        send_frame(8'h33, 8'hFF, k);
        send_frame(8'h34, 8'h05, m);
        repeat (20) @(posedge clk);
        #1;
        send_byte(ABORT_BYTE, m);
        add_seg(8'h33, m - k - 2, 1'b0);
        @(negedge clk);
        check("abort_action", bus.action, 8'h30);
        check("abort_count", bus.fifo_count, 0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_err", bus.err_pulse, 1'b0);
        repeat (80) @(negedge clk);
        check("abort_no_replay", bus.busy, 1'b0);
        wait_idle("abort");

        // Reset in the middle of a run with a frame queued.
        add_seg(ACT_IDLE, 1, 1'b0);
        send_frame(8'h32, 8'h0A, k);
        send_frame(8'h33, 8'h02, m);
        repeat (30) @(posedge clk);
        #1;
        r = cyc;
        rst = 1'b1;
        @(posedge clk); #1;
        add_seg(8'h32, r + 1 - (k + 2), 1'b0);
        @(negedge clk);
        check("rst_action", bus.action, 8'h30);
        check("rst_count", bus.fifo_count, 0);
        check("rst_rx_ready", bus.rx_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("rst_no_replay", bus.busy, 1'b0);
        wait_idle("reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
